// File: rtl/wash_pkg.sv
// wash_pkg: run-state and phase encodings plus the default prescaler length
// shared by the wash controller and its bench.
package wash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RESERVE = 2'b01,
        ST_RUN     = 2'b10,
        ST_PAUSE   = 2'b11
    } run_t;

    typedef enum logic [2:0] {
        PH_NONE  = 3'd0,
        PH_SOAK  = 3'd1,
        PH_WASH  = 3'd2,
        PH_RINSE = 3'd3,
        PH_SPIN  = 3'd4
    } phase_t;

    localparam int DEFAULT_N = 100_000_000;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on a 0->1 transition of d; a level already high
// when reset releases must drop once before it can produce a pulse.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic prev;
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= d;
            armed <= armed | ~d;
        end
    end

    assign pulse = d & ~prev & armed;

endmodule

// File: rtl/wash_ctrl.sv
// wash_ctrl: washing-machine sequencer with reservation, pause/resume,
// soak/wash/rinse/spin phases timed in ticks, and a completion buzzer.
module wash_ctrl
    import wash_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int T_SOAK  = 60,
    parameter int T_WASH  = 120,
    parameter int T_RINSE = 90,
    parameter int T_SPIN  = 60,
    parameter int T_BUZZ  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       power_light,
    input  logic       start_pause,
    input  logic [6:0] rest_time,
    output logic [1:0] run_state,
    output logic [2:0] phase,
    output logic [7:0] phase_left,
    output logic       done,
    output logic       buzzer
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    run_t          state_q, state_n;
    run_t          resume_q, resume_n;
    phase_t        phase_q, phase_n;
    logic [7:0]    left_q, left_n;
    logic          done_q, done_n;
    logic          buzz_q, buzz_n;
    logic [7:0]    bcnt_q, bcnt_n;
    logic [PW-1:0] presc_q, presc_n;
    logic          start_edge;
    logic          run_en;
    logic          tick;
    phase_t        nxt_phase;

    function automatic logic [7:0] dur(phase_t p);
        return p == PH_SOAK  ? 8'(T_SOAK)  :
               p == PH_WASH  ? 8'(T_WASH)  :
               p == PH_RINSE ? 8'(T_RINSE) :
               p == PH_SPIN  ? 8'(T_SPIN)  : 8'd0;
    endfunction

    rise_detect u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (start_pause),
        .pulse (start_edge)
    );

    // A pause request in RUN freezes the prescaler in the same cycle, so a
    // coincident tick never happens.
    assign run_en    = (state_q == ST_RUN && !start_edge) || buzz_q;
    assign tick      = run_en && presc_q == PW'(N - 1);
    assign nxt_phase = phase_t'(phase_q + 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            resume_q <= ST_RESERVE;
            phase_q  <= PH_NONE;
            left_q   <= '0;
            done_q   <= 1'b0;
            buzz_q   <= 1'b0;
            bcnt_q   <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_n;
            resume_q <= resume_n;
            phase_q  <= phase_n;
            left_q   <= left_n;
            done_q   <= done_n;
            buzz_q   <= buzz_n;
            bcnt_q   <= bcnt_n;
            presc_q  <= presc_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        resume_n = resume_q;
        phase_n  = phase_q;
        left_n   = left_q;
        done_n   = done_q;
        buzz_n   = buzz_q;
        bcnt_n   = bcnt_q;
        presc_n  = run_en ? (tick ? '0 : presc_q + 1'b1) : presc_q;
        if (!power_light) begin
            state_n  = ST_IDLE;
            resume_n = ST_RESERVE;
            phase_n  = PH_NONE;
            left_n   = '0;
            done_n   = 1'b0;
            buzz_n   = 1'b0;
            bcnt_n   = '0;
            presc_n  = '0;
        end else begin
            if (buzz_q && tick) begin
                bcnt_n = bcnt_q - 8'd1;
                buzz_n = bcnt_q != 8'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        done_n = 1'b0;
                        buzz_n = 1'b0;
                        bcnt_n = '0;
                        if (rest_time != '0) begin
                            state_n = ST_RESERVE;
                        end else begin
                            state_n = ST_RUN;
                            phase_n = PH_SOAK;
                            left_n  = 8'(T_SOAK);
                            presc_n = '0;
                        end
                    end
                end
                ST_RESERVE: begin
                    if (rest_time == '0) begin
                        state_n = ST_RUN;
                        phase_n = PH_SOAK;
                        left_n  = 8'(T_SOAK);
                        presc_n = '0;
                    end else if (start_edge) begin
                        state_n  = ST_PAUSE;
                        resume_n = ST_RESERVE;
                    end
                end
                ST_RUN: begin
                    if (start_edge) begin
                        state_n  = ST_PAUSE;
                        resume_n = ST_RUN;
                    end else if (tick) begin
                        if (left_q > 8'd1) begin
                            left_n = left_q - 8'd1;
                        end else if (phase_q == PH_SPIN) begin
                            state_n = ST_IDLE;
                            phase_n = PH_NONE;
                            left_n  = '0;
                            done_n  = 1'b1;
                            buzz_n  = 1'b1;
                            bcnt_n  = 8'(T_BUZZ);
                            presc_n = '0;
                        end else begin
                            phase_n = nxt_phase;
                            left_n  = dur(nxt_phase);
                            presc_n = '0;
                        end
                    end
                end
                default: begin
                    if (start_edge) state_n = resume_q;
                end
            endcase
        end
    end

    assign run_state  = state_q;
    assign phase      = phase_q;
    assign phase_left = left_q;
    assign done       = done_q;
    assign buzzer     = buzz_q;

endmodule

// File: tb/tb_wash_ctrl.sv
// tb_wash_ctrl: directed vector table for the normal program flow plus
// hand-written sequences for pause timing, power-off and mid-press reset.
module tb_wash_ctrl;

    localparam int N       = 4;
    localparam int T_SOAK  = 2;
    localparam int T_WASH  = 3;
    localparam int T_RINSE = 2;
    localparam int T_SPIN  = 2;
    localparam int T_BUZZ  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       power_light = 1'b0;
    logic       start_pause = 1'b0;
    logic [6:0] rest_time = '0;
    logic [1:0] run_state;
    logic [2:0] phase;
    logic [7:0] phase_left;
    logic       done;
    logic       buzzer;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wash_ctrl #(
        .N(N), .T_SOAK(T_SOAK), .T_WASH(T_WASH), .T_RINSE(T_RINSE),
        .T_SPIN(T_SPIN), .T_BUZZ(T_BUZZ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .power_light (power_light),
        .start_pause (start_pause),
        .rest_time   (rest_time),
        .run_state   (run_state),
        .phase       (phase),
        .phase_left  (phase_left),
        .done        (done),
        .buzzer      (buzzer)
    );

    typedef struct {
        logic       pw;
        logic       st;
        logic [6:0] rt;
        int         cyc;
        logic [1:0] rs;
        logic [2:0] ph;
        logic [7:0] pl;
        logic       dn;
        logic       bz;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic pw, input logic st, input logic [6:0] rt, input int cyc,
                       input logic [1:0] rs, input logic [2:0] ph, input logic [7:0] pl,
                       input logic dn, input logic bz);
        vec_t v;
        v = '{pw: pw, st: st, rt: rt, cyc: cyc, rs: rs, ph: ph, pl: pl, dn: dn, bz: bz};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] rs, input logic [2:0] ph,
                         input logic [7:0] pl, input logic dn, input logic bz);
        n_checks++;
        if ({run_state, phase, phase_left, done, buzzer} !== {rs, ph, pl, dn, bz}) begin
            n_fail++;
            $display("FAIL %s: got rs=%0d ph=%0d left=%0d done=%0b buz=%0b, expected rs=%0d ph=%0d left=%0d done=%0b buz=%0b",
                     name, run_state, phase, phase_left, done, buzzer, rs, ph, pl, dn, bz);
        end
    endtask

    task automatic step(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin
        // pw st rt cyc | rs ph left done buz
        add(1, 0, 0, 1,  0, 0, 0, 0, 0);
        add(1, 1, 0, 1,  2, 1, 2, 0, 0);
        add(1, 0, 0, 3,  2, 1, 2, 0, 0);
        add(1, 0, 0, 1,  2, 1, 1, 0, 0);
        add(1, 0, 0, 3,  2, 1, 1, 0, 0);
        add(1, 0, 0, 1,  2, 2, 3, 0, 0);
        add(1, 0, 0, 4,  2, 2, 2, 0, 0);
        add(1, 0, 0, 4,  2, 2, 1, 0, 0);
        add(1, 0, 0, 4,  2, 3, 2, 0, 0);
        add(1, 0, 0, 8,  2, 4, 2, 0, 0);
        add(1, 0, 0, 7,  2, 4, 1, 0, 0);
        add(1, 0, 0, 1,  0, 0, 0, 1, 1);
        add(1, 0, 0, 7,  0, 0, 0, 1, 1);
        add(1, 0, 0, 1,  0, 0, 0, 1, 0);
        add(1, 0, 0, 5,  0, 0, 0, 1, 0);
        add(1, 1, 3, 1,  1, 0, 0, 0, 0);
        add(1, 0, 3, 3,  1, 0, 0, 0, 0);
        add(1, 0, 0, 1,  2, 1, 2, 0, 0);
        add(1, 1, 0, 1,  3, 1, 2, 0, 0);
        add(1, 0, 0, 20, 3, 1, 2, 0, 0);
        add(1, 1, 0, 1,  2, 1, 2, 0, 0);
        add(1, 0, 0, 3,  2, 1, 2, 0, 0);
        add(1, 0, 0, 1,  2, 1, 1, 0, 0);
        add(0, 0, 0, 1,  0, 0, 0, 0, 0);
        add(1, 0, 0, 3,  0, 0, 0, 0, 0);
        add(1, 1, 5, 1,  1, 0, 0, 0, 0);
        add(1, 0, 5, 1,  1, 0, 0, 0, 0);
        add(1, 1, 5, 1,  3, 0, 0, 0, 0);
        add(1, 0, 0, 5,  3, 0, 0, 0, 0);
        add(1, 1, 0, 1,  1, 0, 0, 0, 0);
        add(1, 0, 0, 1,  2, 1, 2, 0, 0);
        add(0, 0, 0, 1,  0, 0, 0, 0, 0);
        add(1, 1, 1, 1,  1, 0, 0, 0, 0);
        add(1, 0, 1, 1,  1, 0, 0, 0, 0);
        add(1, 1, 0, 1,  2, 1, 2, 0, 0);
        add(1, 0, 0, 1,  2, 1, 2, 0, 0);
        add(0, 1, 0, 1,  0, 0, 0, 0, 0);
        add(1, 0, 0, 2,  0, 0, 0, 0, 0);

        power_light = 1'b1;
        #12;
        check("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        foreach (vecs[i]) begin
            power_light = vecs[i].pw;
            start_pause = vecs[i].st;
            rest_time   = vecs[i].rt;
            step(vecs[i].cyc);
            check($sformatf("vec%0d", i), vecs[i].rs, vecs[i].ph, vecs[i].pl, vecs[i].dn, vecs[i].bz);
        end

        // Pause mid-tick in WASH: resume must continue from the frozen prescaler.
        start_pause = 1'b1; step(1); check("p_start", 2, 1, 2, 0, 0);
        start_pause = 1'b0; step(7); check("p_soak_end", 2, 1, 1, 0, 0);
        step(1); check("p_wash3", 2, 2, 3, 0, 0);
        step(4); check("p_wash2", 2, 2, 2, 0, 0);
        step(2); check("p_wash2_mid", 2, 2, 2, 0, 0);
        start_pause = 1'b1; step(1); check("p_pause", 3, 2, 2, 0, 0);
        start_pause = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            check($sformatf("p_frozen%0d", k), 3, 2, 2, 0, 0);
        end
        start_pause = 1'b1; step(1); check("p_resume", 2, 2, 2, 0, 0);
        start_pause = 1'b0; step(1); check("p_resume_c1", 2, 2, 2, 0, 0);
        step(1); check("p_resume_tick", 2, 2, 1, 0, 0);
        step(3); check("p_pre_tick", 2, 2, 1, 0, 0);
        start_pause = 1'b1; step(1); check("p_pause_vs_tick", 3, 2, 1, 0, 0);
        start_pause = 1'b0; step(1); check("p_pause_hold", 3, 2, 1, 0, 0);
        start_pause = 1'b1; step(1); check("p_resume2", 2, 2, 1, 0, 0);
        start_pause = 1'b0; step(1); check("p_rinse", 2, 3, 2, 0, 0);

        power_light = 1'b0; step(1); check("pwr_off_rinse", 0, 0, 0, 0, 0);
        power_light = 1'b1; step(5); check("pwr_restored", 0, 0, 0, 0, 0);

        // Reset during SPIN while start is held; release must not restart.
        start_pause = 1'b1; step(1); check("r_start", 2, 1, 2, 0, 0);
        step(28); check("r_spin", 2, 4, 2, 0, 0);
        #2 rst_n = 1'b0;
        #1 check("r_async", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(5); check("r_no_edge", 0, 0, 0, 0, 0);
        start_pause = 1'b0; step(1); check("r_release", 0, 0, 0, 0, 0);
        start_pause = 1'b1; step(1); check("r_new_press", 2, 1, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wash_ctrl.md
WASH_CTRL -- requirements
Module: wash_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter N, default 100_000_000: clk cycles per 1 s tick.
REQ-003 Parameters T_SOAK, T_WASH, T_RINSE, T_SPIN, defaults 60/120/90/60: phase durations in ticks, each 1..255.
REQ-004 Parameter T_BUZZ, default 5: buzzer duration in ticks, 1..255.
REQ-005 Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- power_light  in  1  power enable, 0 = off
- start_pause  in  1  start/pause button level, debounced upstream
- rest_time  in  7  reservation seconds remaining, from the reservation counter
- run_state  out  2  00 IDLE, 01 RESERVE, 10 RUN, 11 PAUSE; drives the reservation counter
- phase  out  3  0 NONE, 1 SOAK, 2 WASH, 3 RINSE, 4 SPIN
- phase_left  out  8  ticks remaining in the current phase
- done  out  1  program complete, level
- buzzer  out  1  completion alert

Function
REQ-006 start_pause SHALL be edge-detected internally; only a 0->1 transition (start_edge, one cycle) acts.
REQ-007 The tick prescaler SHALL count 0..N-1 and emit a one-cycle tick at N-1; it runs only in RUN and while the buzzer is active, holds its value in PAUSE, and clears to 0 on every phase entry.
REQ-008 power_light==0 SHALL synchronously force IDLE, phase NONE, phase_left 0, done 0, buzzer 0, prescaler 0, and clear the resume target; it has priority over all other events.
REQ-009 IDLE + start_edge: go to RESERVE if rest_time!=0, else RUN/SOAK with phase_left=T_SOAK; done and buzzer clear.
REQ-010 RESERVE + rest_time==0: go to RUN/SOAK, phase_left=T_SOAK, on the next cycle.
REQ-011 RESERVE + start_edge with rest_time!=0: go to PAUSE, resume target = RESERVE.
REQ-012 RESERVE, rest_time==0 and start_edge in the same cycle: expiry wins (go RUN/SOAK) and the edge is discarded.
REQ-013 RUN + start_edge: go to PAUSE, resume target = RUN; phase, phase_left and prescaler are frozen.
REQ-014 PAUSE + start_edge: return to the resume target with all state unchanged; no other input leaves PAUSE except power-off and reset.
REQ-015 RUN + tick: decrement phase_left if it is >1; if it is ==1, advance SOAK->WASH->RINSE->SPIN and load the new duration.
REQ-016 A tick with phase_left==1 in SPIN SHALL go to IDLE, phase NONE, phase_left 0, done=1, buzzer=1.
REQ-017 In the same cycle, RUN start_edge and tick: pause wins and the tick is discarded.
REQ-018 buzzer SHALL stay high for exactly T_BUZZ ticks after completion, then drop; done holds until the next start_edge or power-off.
REQ-019 rest_time is treated as read-only and is never latched; the IDLE decision uses its value in the start_edge cycle.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 rst_n low SHALL asynchronously set run_state 00, phase 0, phase_left 0, done 0, buzzer 0, prescaler 0, edge-detect history 0, resume target RESERVE.
REQ-022 Reset release mid-press (start_pause already 1) SHALL NOT generate start_edge.

Structure
REQ-023 Shared package wash_pkg: run_state encodings, phase encodings, default N.
REQ-024 One sub-module rise_detect (clk, rst_n, d -> pulse) provides start_edge; the FSM, prescaler and buzzer timer live in wash_ctrl.

Verification (N=4, T_SOAK=2, T_WASH=3, T_RINSE=2, T_SPIN=2, T_BUZZ=2)
REQ-025 rest_time=0, press start in IDLE -> run_state 10, phase 1, phase_left 2; phases 1,2,3,4 last 8,12,8,8 cycles; then run_state 00, done=1, buzzer high for 8 cycles.
REQ-026 rest_time=3, press start -> run_state 01; drive rest_time to 0 -> next cycle run_state 10, phase 1.
REQ-027 RUN WASH with phase_left=2, press start -> run_state 11, outputs frozen for 20 cycles; press again -> run_state 10, remaining count continues from the frozen prescaler.
REQ-028 RESERVE: rest_time 1->0 coincident with a start rising edge -> run_state 10, not 11.
REQ-029 power_light dropped during RINSE -> next cycle all outputs 0; restoring power leaves the block IDLE with no action until start is pressed.
REQ-030 rst_n asserted mid-SPIN with start held high, then released -> outputs 0 immediately, no start_edge after release.
